alu_dispatch: RTL and testbench

- Dispatch stage that produces ALU reservation-station entries (the producer side of alu_reserv_inf).
- Accepts one decoded ALU instruction per cycle, allocates a ROB tag and resolves each source operand to a value or a pending tag.
- Operand sources are the rename table, register file, CDB bypass, commit bypass and ROB ready-value lookup.
- Renames the destination register and drives a one-cycle registered entry to the ALU reservation station.

---
 rtl/alu_dispatch_if.sv | 90 +++++++++
 rtl/alu_dispatch.sv | 162 ++++++++++++++++
 tb/tb_alu_dispatch.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_dispatch_if.sv
// Purpose: producer-side bundle between the ALU dispatch stage and its neighbours
//          (decode, regfile, ROB, CDB and the ALU reservation station).
// Ports  : master = dispatch stage, slave = everything around it.
//          inst_imm / inst_use_imm exist only when DISPATCH_IMM_EN is defined.
interface alu_dispatch_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int OP_W   = 4,
  parameter int RIDX_W = 5
);
  // decoded instruction
  logic              flush;
  logic              inst_valid;
  logic              inst_ready;
  logic [OP_W-1:0]   inst_op;
  logic [RIDX_W-1:0] inst_rd;
  logic [RIDX_W-1:0] inst_rs1;
  logic [RIDX_W-1:0] inst_rs2;
`ifdef DISPATCH_IMM_EN
  logic [DATA_W-1:0] inst_imm;
  logic              inst_use_imm;
`endif
  // register file
  logic [RIDX_W-1:0] rf_raddr1;
  logic [RIDX_W-1:0] rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  // ROB lookup / allocate / commit
  logic [TAG_W-1:0]  rob_qtag1;
  logic [TAG_W-1:0]  rob_qtag2;
  logic              rob_qready1;
  logic              rob_qready2;
  logic [DATA_W-1:0] rob_qval1;
  logic [DATA_W-1:0] rob_qval2;
  logic              rob_full;
  logic              rob_alloc;
  logic [TAG_W-1:0]  rob_alloc_tag;
  logic [RIDX_W-1:0] rob_alloc_rd;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic [RIDX_W-1:0] commit_rd;
  logic [DATA_W-1:0] commit_val;
  // result broadcast
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_val;
  // reservation station entry
  logic              rs_full;
  logic              rs_ce;
  logic [TAG_W-1:0]  rs_target;
  logic [DATA_W-1:0] rs_val1;
  logic [DATA_W-1:0] rs_val2;
  logic [TAG_W-1:0]  rs_tag1;
  logic [TAG_W-1:0]  rs_tag2;
  logic [OP_W-1:0]   rs_op;

  modport master (
    input  flush, inst_valid, inst_op, inst_rd, inst_rs1, inst_rs2,
`ifdef DISPATCH_IMM_EN
    input  inst_imm, inst_use_imm,
`endif
    output inst_ready,
    output rf_raddr1, rf_raddr2,
    input  rf_rdata1, rf_rdata2,
    output rob_qtag1, rob_qtag2,
    input  rob_qready1, rob_qready2, rob_qval1, rob_qval2, rob_full,
    output rob_alloc, rob_alloc_tag, rob_alloc_rd,
    input  commit_valid, commit_tag, commit_rd, commit_val,
    input  cdb_valid, cdb_tag, cdb_val,
    input  rs_full,
    output rs_ce, rs_target, rs_val1, rs_val2, rs_tag1, rs_tag2, rs_op
  );

  modport slave (
    output flush, inst_valid, inst_op, inst_rd, inst_rs1, inst_rs2,
`ifdef DISPATCH_IMM_EN
    output inst_imm, inst_use_imm,
`endif
    input  inst_ready,
    input  rf_raddr1, rf_raddr2,
    output rf_rdata1, rf_rdata2,
    input  rob_qtag1, rob_qtag2,
    output rob_qready1, rob_qready2, rob_qval1, rob_qval2, rob_full,
    input  rob_alloc, rob_alloc_tag, rob_alloc_rd,
    output commit_valid, commit_tag, commit_rd, commit_val,
    output cdb_valid, cdb_tag, cdb_val,
    output rs_full,
    input  rs_ce, rs_target, rs_val1, rs_val2, rs_tag1, rs_tag2, rs_op
  );
endinterface

// File: rtl/alu_dispatch.sv
// Purpose: ALU dispatch - allocates ROB tag, resolves operands, renames rd, emits RS entry.
// Latency: accept at posedge N -> rs_*/rob_alloc* registered, valid in cycle N+1 only.
// Backpressure: inst_ready = !rst && !flush && !rs_full && !rob_full; entry in flight is never dropped.
// Ports: clk, rst (async, active-high), bus (alu_dispatch_if.master) carrying all other signals.
// Option: DISPATCH_IMM_EN adds inst_imm / inst_use_imm (src2 from immediate).
module alu_dispatch #(
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 5,
  parameter int ROB_DEPTH = 16,
  parameter int REG_NUM   = 32,
  parameter int OP_W      = 4
) (
  input logic           clk,
  input logic           rst,
  alu_dispatch_if.master bus
);

  localparam logic [TAG_W-1:0] TAG_INVALID = '1;
  localparam logic [TAG_W-1:0] TAG_LAST    = TAG_W'(ROB_DEPTH - 1);

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [TAG_W-1:0]  tag;
  } opnd_t;

  logic [TAG_W-1:0]  r_rename [REG_NUM];
  logic [TAG_W-1:0]  r_next_tag;

  logic              r_rs_ce;
  logic [TAG_W-1:0]  r_rs_target;
  logic [DATA_W-1:0] r_rs_val1;
  logic [DATA_W-1:0] r_rs_val2;
  logic [TAG_W-1:0]  r_rs_tag1;
  logic [TAG_W-1:0]  r_rs_tag2;
  logic [OP_W-1:0]   r_rs_op;
  logic              r_rob_alloc;
  logic [4:0]        r_rob_alloc_rd;

  logic              w_ready;
  logic              w_accept;
  logic [TAG_W-1:0]  w_map1;
  logic [TAG_W-1:0]  w_map2;
  opnd_t             w_src1;
  opnd_t             w_src2;

  // Operand resolution, first match wins. All lookups use the mapping as it
  // stands before this cycle's rename, so rs == rd sees the older producer.
  function automatic opnd_t f_resolve(
    input logic [4:0]        rs,
    input logic [TAG_W-1:0]  map,
    input logic [DATA_W-1:0] rf_val,
    input logic              q_rdy,
    input logic [DATA_W-1:0] q_val,
    input logic              cdb_v,
    input logic [TAG_W-1:0]  cdb_t,
    input logic [DATA_W-1:0] cdb_d,
    input logic              cmt_v,
    input logic [TAG_W-1:0]  cmt_t,
    input logic [DATA_W-1:0] cmt_d
  );
    opnd_t o;
    o.val = '0;
    o.tag = TAG_INVALID;
    if (rs == 5'd0) begin
      o.val = '0;
    end else if (map == TAG_INVALID) begin
      o.val = rf_val;
    end else if (cdb_v && (cdb_t == map)) begin
      o.val = cdb_d;
    end else if (cmt_v && (cmt_t == map)) begin
      o.val = cmt_d;
    end else if (q_rdy) begin
      o.val = q_val;
    end else begin
      o.tag = map;
    end
    return o;
  endfunction

  assign w_ready  = !rst && !bus.flush && !bus.rs_full && !bus.rob_full;
  assign w_accept = bus.inst_valid && w_ready;

  assign w_map1 = r_rename[bus.inst_rs1];
  assign w_map2 = r_rename[bus.inst_rs2];

  assign bus.inst_ready = w_ready;
  assign bus.rf_raddr1  = bus.inst_rs1;
  assign bus.rf_raddr2  = bus.inst_rs2;
  assign bus.rob_qtag1  = w_map1;
  assign bus.rob_qtag2  = w_map2;

  always_comb begin
    w_src1 = f_resolve(bus.inst_rs1, w_map1, bus.rf_rdata1, bus.rob_qready1, bus.rob_qval1,
                       bus.cdb_valid, bus.cdb_tag, bus.cdb_val,
                       bus.commit_valid, bus.commit_tag, bus.commit_val);
    w_src2 = f_resolve(bus.inst_rs2, w_map2, bus.rf_rdata2, bus.rob_qready2, bus.rob_qval2,
                       bus.cdb_valid, bus.cdb_tag, bus.cdb_val,
                       bus.commit_valid, bus.commit_tag, bus.commit_val);
`ifdef DISPATCH_IMM_EN
    if (bus.inst_use_imm) begin
      w_src2.val = bus.inst_imm;
      w_src2.tag = TAG_INVALID;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs_ce        <= 1'b0;
      r_rob_alloc    <= 1'b0;
      r_rs_target    <= TAG_INVALID;
      r_rs_tag1      <= TAG_INVALID;
      r_rs_tag2      <= TAG_INVALID;
      r_rs_val1      <= '0;
      r_rs_val2      <= '0;
      r_rs_op        <= '0;
      r_rob_alloc_rd <= '0;
      r_next_tag     <= '0;
      for (int i = 0; i < REG_NUM; i++) r_rename[i] <= TAG_INVALID;
    end else if (bus.flush) begin
      // Flush outranks both commit and accept (w_accept is already low here).
      r_rs_ce     <= 1'b0;
      r_rob_alloc <= 1'b0;
      r_next_tag  <= '0;
      for (int i = 0; i < REG_NUM; i++) r_rename[i] <= TAG_INVALID;
    end else begin
      r_rs_ce     <= w_accept;
      r_rob_alloc <= w_accept;

      // Only retire the mapping if it still points at the committing tag;
      // a younger producer of the same rd must keep its mapping.
      if (bus.commit_valid && (r_rename[bus.commit_rd] == bus.commit_tag))
        r_rename[bus.commit_rd] <= TAG_INVALID;

      if (w_accept) begin
        r_rs_target    <= r_next_tag;
        r_rs_val1      <= w_src1.val;
        r_rs_tag1      <= w_src1.tag;
        r_rs_val2      <= w_src2.val;
        r_rs_tag2      <= w_src2.tag;
        r_rs_op        <= bus.inst_op;
        r_rob_alloc_rd <= bus.inst_rd;
        r_next_tag     <= (r_next_tag == TAG_LAST) ? '0 : r_next_tag + 1'b1;
        // Later assignment: a same-cycle rename beats the commit clear above.
        if (bus.inst_rd != 5'd0)
          r_rename[bus.inst_rd] <= r_next_tag;
      end
    end
  end

  assign bus.rs_ce         = r_rs_ce;
  assign bus.rs_target     = r_rs_target;
  assign bus.rs_val1       = r_rs_val1;
  assign bus.rs_val2       = r_rs_val2;
  assign bus.rs_tag1       = r_rs_tag1;
  assign bus.rs_tag2       = r_rs_tag2;
  assign bus.rs_op         = r_rs_op;
  assign bus.rob_alloc     = r_rob_alloc;
  assign bus.rob_alloc_tag = r_rs_target;
  assign bus.rob_alloc_rd  = r_rob_alloc_rd;

endmodule

// File: tb/tb_alu_dispatch.sv
// Purpose: directed self-checking bench for alu_dispatch.
// Ports: drives the slave side of alu_dispatch_if; regfile modelled as a small array.
// Option: DISPATCH_IMM_EN enables the immediate-operand vector.
module tb_alu_dispatch;

  logic clk;
  logic rst;
  logic [31:0] rf [32];
  int n_checks = 0;
  int n_errors = 0;

  alu_dispatch_if #(.DATA_W(32), .TAG_W(5), .OP_W(4), .RIDX_W(5)) bus ();

  alu_dispatch #(.DATA_W(32), .TAG_W(5), .ROB_DEPTH(16), .REG_NUM(32), .OP_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rf_rdata1 = rf[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf[bus.rf_raddr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2);
    bus.inst_op    = op;
    bus.inst_rd    = rd;
    bus.inst_rs1   = rs1;
    bus.inst_rs2   = rs2;
    bus.inst_valid = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rst = 1'b1;
    bus.flush = 0; bus.inst_valid = 0; bus.inst_op = 0;
    bus.inst_rd = 0; bus.inst_rs1 = 0; bus.inst_rs2 = 0;
`ifdef DISPATCH_IMM_EN
    bus.inst_imm = 0; bus.inst_use_imm = 0;
`endif
    bus.rob_qready1 = 0; bus.rob_qready2 = 0; bus.rob_qval1 = 0; bus.rob_qval2 = 0;
    bus.rob_full = 0; bus.rs_full = 0;
    bus.commit_valid = 0; bus.commit_tag = 0; bus.commit_rd = 0; bus.commit_val = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_val = 0;

    // reset state
    #2;
    chk("rdy_in_rst", bus.inst_ready, 0);
    chk("rst_ce", bus.rs_ce, 0);
    chk("rst_alloc", bus.rob_alloc, 0);
    chk("rst_target", bus.rs_target, 32'h1F);
    chk("rst_tag1", bus.rs_tag1, 32'h1F);
    chk("rst_tag2", bus.rs_tag2, 32'h1F);
    chk("rst_alloc_tag", bus.rob_alloc_tag, 32'h1F);
    chk("rst_val1", bus.rs_val1, 0);
    chk("rst_op", bus.rs_op, 0);
    chk("rst_alloc_rd", bus.rob_alloc_rd, 0);
    #10 rst = 1'b0;
    #1 chk("rdy_idle", bus.inst_ready, 1);
    cyc();

    // ADD r3 = r1 + r2 from the regfile
    rf[1] = 5; rf[2] = 7;
    put(4'h1, 3, 1, 2);
    cyc(); bus.inst_valid = 0;
    chk("t1_ce", bus.rs_ce, 1);
    chk("t1_alloc", bus.rob_alloc, 1);
    chk("t1_target", bus.rs_target, 0);
    chk("t1_alloc_tag", bus.rob_alloc_tag, 0);
    chk("t1_val1", bus.rs_val1, 5);
    chk("t1_val2", bus.rs_val2, 7);
    chk("t1_tag1", bus.rs_tag1, 32'h1F);
    chk("t1_tag2", bus.rs_tag2, 32'h1F);
    chk("t1_rd", bus.rob_alloc_rd, 3);
    chk("t1_op", bus.rs_op, 1);

    // r4 = r3 + r3, producer tag0 pending
    put(4'h2, 4, 3, 3);
    #1;
    chk("t2_raddr1", bus.rf_raddr1, 3);
    chk("t2_qtag1", bus.rob_qtag1, 0);
    cyc(); bus.inst_valid = 0;
    chk("t2_target", bus.rs_target, 1);
    chk("t2_tag1", bus.rs_tag1, 0);
    chk("t2_tag2", bus.rs_tag2, 0);
    chk("t2_val1", bus.rs_val1, 0);

    // r5 = r3 + r3 with tag0 on the CDB in the dispatch cycle
    put(4'h3, 5, 3, 3);
    bus.cdb_valid = 1; bus.cdb_tag = 0; bus.cdb_val = 32'h2A;
    cyc(); bus.inst_valid = 0; bus.cdb_valid = 0;
    chk("t3_target", bus.rs_target, 2);
    chk("t3_val1", bus.rs_val1, 32'h2A);
    chk("t3_val2", bus.rs_val2, 32'h2A);
    chk("t3_tag1", bus.rs_tag1, 32'h1F);
    chk("t3_tag2", bus.rs_tag2, 32'h1F);

    // r6 = r3 + r4; tag1 (r4) commits this cycle -> bypass, rename[4] cleared
    rf[4] = 32'h44;
    put(4'h4, 6, 3, 4);
    bus.commit_valid = 1; bus.commit_tag = 1; bus.commit_rd = 4; bus.commit_val = 32'h99;
    cyc(); bus.inst_valid = 0; bus.commit_valid = 0;
    chk("t4_target", bus.rs_target, 3);
    chk("t4_tag1", bus.rs_tag1, 0);
    chk("t4_val2", bus.rs_val2, 32'h99);
    chk("t4_tag2", bus.rs_tag2, 32'h1F);

    // r7 = r3 + r4; r3 value ready in ROB, r4 now from regfile
    put(4'h5, 7, 3, 4);
    bus.rob_qready1 = 1; bus.rob_qval1 = 32'h55;
    cyc(); bus.inst_valid = 0; bus.rob_qready1 = 0;
    chk("t5_target", bus.rs_target, 4);
    chk("t5_val1", bus.rs_val1, 32'h55);
    chk("t5_tag1", bus.rs_tag1, 32'h1F);
    chk("t5_val2", bus.rs_val2, 32'h44);
    chk("t5_tag2", bus.rs_tag2, 32'h1F);

    // r3 = r3 + r0 (tag5) while tag0/r3 commits: old producer read, new mapping wins
    put(4'h6, 3, 3, 0);
    bus.commit_valid = 1; bus.commit_tag = 0; bus.commit_rd = 3; bus.commit_val = 32'h11;
    cyc(); bus.inst_valid = 0; bus.commit_valid = 0;
    chk("t6_target", bus.rs_target, 5);
    chk("t6_val1_commit_byp", bus.rs_val1, 32'h11);
    chk("t6_val2_r0", bus.rs_val2, 0);
    chk("t6_tag2_r0", bus.rs_tag2, 32'h1F);
    chk("t6_rename_r3", bus.rob_qtag1, 5);
    chk("t6_rename_r0", bus.rob_qtag2, 32'h1F);

    // rd == 0: allocates tag, no rename
    put(4'h7, 0, 1, 2);
    cyc(); bus.inst_valid = 0;
    chk("t7_target", bus.rs_target, 6);
    chk("t7_rd", bus.rob_alloc_rd, 0);
    chk("t7_val1", bus.rs_val1, 5);
    bus.inst_rs1 = 0; bus.inst_rs2 = 3;
    #1;
    chk("t7_rename_r0", bus.rob_qtag1, 32'h1F);
    chk("t7_rename_r3", bus.rob_qtag2, 5);
    cyc();
    chk("idle_ce", bus.rs_ce, 0);
    chk("idle_alloc", bus.rob_alloc, 0);

    // flush with an instruction offered: not accepted, mappings cleared
    put(4'h8, 9, 1, 2);
    bus.flush = 1;
    #1 chk("fl_rdy", bus.inst_ready, 0);
    cyc(); bus.flush = 0; bus.inst_valid = 0;
    chk("fl_ce", bus.rs_ce, 0);
    chk("fl_alloc", bus.rob_alloc, 0);
    bus.inst_rs1 = 3; bus.inst_rs2 = 7;
    #1;
    chk("fl_rename_r3", bus.rob_qtag1, 32'h1F);
    chk("fl_rename_r7", bus.rob_qtag2, 32'h1F);

    // 17 back-to-back accepts: targets 0..15 then 0
    put(4'h1, 10, 1, 2);
    for (int i = 0; i < 17; i++) begin
      cyc();
      chk("wrap_ce", bus.rs_ce, 1);
      chk("wrap_target", bus.rs_target, i % 16);
    end

    // rs_full for 3 cycles with inst_valid held
    bus.rs_full = 1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("full_rdy", bus.inst_ready, 0);
      cyc();
      chk("full_ce", bus.rs_ce, 0);
    end
    bus.rs_full = 0;
    #1 chk("unfull_rdy", bus.inst_ready, 1);
    cyc(); bus.inst_valid = 0;
    chk("unfull_ce", bus.rs_ce, 1);
    chk("unfull_target", bus.rs_target, 1);
    bus.rob_full = 1;
    #1 chk("robfull_rdy", bus.inst_ready, 0);
    bus.rob_full = 0;

`ifdef DISPATCH_IMM_EN
    // rs2 = r10 is renamed (tag1) but the immediate replaces it
    put(4'h9, 11, 1, 10);
    bus.inst_use_imm = 1; bus.inst_imm = 32'h1234;
    cyc(); bus.inst_valid = 0; bus.inst_use_imm = 0;
    chk("imm_target", bus.rs_target, 2);
    chk("imm_val2", bus.rs_val2, 32'h1234);
    chk("imm_tag2", bus.rs_tag2, 32'h1F);
`endif

    cyc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
